// File: rtl/counter.sv
// Free-running synchronous up-counter with a programmable step, terminal count
// and reload value; the count flop drives the output directly.
module counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned STEP        = 1,
  parameter longint unsigned RESET_VALUE = 0,
  parameter longint unsigned MAX_VALUE   = (64'd1 << WIDTH) - 64'd1
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  // Parameters are folded to the counter width once so every compare and add
  // below is WIDTH bits; an unreachable MAX_VALUE leaves plain modulo wrap.
  localparam logic [WIDTH-1:0] STEP_W  = STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_W = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_W   = MAX_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q + STEP_W;
    if (count_q == MAX_W) begin
      count_d = RESET_W;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_W;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed test-plan sequence, then randomized
// resets and sub-period reset glitches against an edges-since-reset model.
module tb_counter;

  logic       clk;
  logic       reset;
  logic [7:0] value;

  int n_checks;
  int n_fail;

  // Model: number of rising edges since the last edge that sampled reset high.
  bit model_valid;
  int edges_since_reset;

  counter dut (
    .value (value),
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: value=0x%02h expected 0x%02h", name, $time, got, exp);
    end else begin
      $display("ok   %s at %0t: value=0x%02h", name, $time, got);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      edges_since_reset = 0;
    end else if (model_valid) begin
      edges_since_reset++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model", value, 8'(edges_since_reset % 256));
    end
  end

  initial begin
    model_valid = 1'b0;
    edges_since_reset = 0;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;

    // Power-up and reset: reset high 17..28 ns
    #17 reset = 1'b1;
    #11 reset = 1'b0;
    #2  check("after_reset_25ns", value, 8'h00);
    #6  check("count_35ns", value, 8'h01);
    #10 check("count_45ns", value, 8'h02);
    #10 check("count_55ns", value, 8'h03);
    #1  reset = 1'b1;                          // 57 ns
    #9  check("midreset_65ns", value, 8'h00);  // 66 ns
    #2  reset = 1'b0;                          // 68 ns
    #8  check("release_75ns", value, 8'h01);   // 76 ns
    #190 check("count_265ns", value, 8'h14);   // 266 ns

    // Reset held for 5 edges, then release
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) check("reset_held", value, 8'h00);
    end
    reset = 1'b0;
    @(negedge clk) check("after_held", value, 8'h01);

    // Wrap-around
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (255) @(negedge clk);
    check("wrap_ff", value, 8'hFF);
    @(negedge clk) check("wrap_00", value, 8'h00);
    @(negedge clk) check("wrap_01", value, 8'h01);

    // Reset colliding with the wrap edge
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (255) @(negedge clk);
    check("collide_pre_ff", value, 8'hFF);
    reset = 1'b1;
    @(negedge clk) check("collide_reset", value, 8'h00);
    reset = 1'b0;
    @(negedge clk) check("collide_next", value, 8'h01);

    // Randomized resets plus glitches that never span a rising edge
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 63) == 0);
      if (!reset && $urandom_range(0, 15) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
